// File: rtl/m_wb_uart.sv
// Wishbone classic slave UART: 8N1 transmitter with a one-byte holding register,
// receiver with a one-byte buffer and overrun flag, fixed CLKDIV clocks per bit.
module m_wb_uart #(
    parameter int unsigned CLKDIV = 104,
    parameter int unsigned RXSYNC = 2
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    input  logic       ADR_I,
    input  logic [7:0] DAT_I,
    output logic [7:0] DAT_O,
    output logic       ACK_O,
    output logic       TXD,
    input  logic       RXD,
    output logic       irq
);

    localparam logic [15:0] BitLast  = 16'(CLKDIV - 1);
    localparam logic [15:0] HalfLast = 16'(CLKDIV / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Bus interface
    logic       ack_q;
    logic [7:0] dat_q, dat_d;
    logic       access, wr_data, wr_stat, rd_data;
    logic [7:0] status;

    // Transmitter
    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  txhold_q, txhold_d;
    logic        txfull_q, txfull_d;
    logic        txd_q, txd_d;
    logic        tx_load, txbusy;

    // Receiver
    logic [RXSYNC-1:0] rx_sync_q;
    logic              rxd_s, rx_prev_q;
    state_e            rx_state_q, rx_state_d;
    logic [15:0]       rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic              rx_good;
    logic [7:0]        rxbuf_q, rxbuf_d;
    logic              rxvalid_q, rxvalid_d;
    logic              overrun_q, overrun_d;

    // Side effects happen only on the edge that raises ACK_O.
    assign access  = CYC_I & STB_I & ~ack_q;
    assign wr_data = access & WE_I & ~ADR_I;
    assign wr_stat = access & WE_I & ADR_I;
    assign rd_data = access & ~WE_I & ~ADR_I;

    assign txbusy = (tx_state_q != StIdle) | txfull_q;
    assign status = {4'b0000, txbusy, overrun_q, rxvalid_q, ~txfull_q};

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign TXD   = txd_q;
    assign irq   = rxvalid_q | overrun_q;
    assign rxd_s = rx_sync_q[RXSYNC-1];

    always_comb begin
        dat_d = 8'h00;
        if (access && !WE_I) begin
            dat_d = ADR_I ? status : rxbuf_q;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        txhold_d   = txhold_q;
        txfull_d   = txfull_q;
        tx_load    = 1'b0;
        if (wr_data && !txfull_q) begin
            txhold_d = DAT_I;
            txfull_d = 1'b1;
        end
        unique case (tx_state_q)
            StIdle:  tx_load = txfull_q;
            StStart: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = StData;
                    tx_cnt_d   = BitLast;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_sh_q[0];
                    tx_sh_d    = tx_sh_q >> 1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BitLast;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        txd_d    = tx_sh_q[0];
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (tx_cnt_q == '0) begin
                    // A waiting byte starts straight away: no idle bit between frames.
                    tx_load    = txfull_q;
                    tx_state_d = StIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = StIdle;
        endcase
        if (tx_load) begin
            tx_sh_d    = txhold_q;
            txfull_d   = 1'b0;
            tx_state_d = StStart;
            tx_cnt_d   = BitLast;
            txd_d      = 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_good    = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rxd_s) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = HalfLast;
                end
            end
            StStart: begin
                if (rx_cnt_q == '0) begin
                    if (rxd_s) begin
                        rx_state_d = StIdle;
                    end else begin
                        rx_state_d = StData;
                        rx_cnt_d   = BitLast;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            StData: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rxd_s, rx_sh_q[7:1]};
                    rx_cnt_d = BitLast;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (rx_cnt_q == '0) begin
                    rx_good    = rxd_s;
                    rx_state_d = StIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // A DATA read in the same edge as a new frame frees the buffer, so no overrun;
    // a new overrun beats a simultaneous clear.
    always_comb begin
        rxbuf_d   = rxbuf_q;
        rxvalid_d = rxvalid_q;
        overrun_d = overrun_q;
        if (rd_data) begin
            rxvalid_d = 1'b0;
        end
        if (wr_stat && DAT_I[2]) begin
            overrun_d = 1'b0;
        end
        if (rx_good) begin
            if (rxvalid_q && !rd_data) begin
                overrun_d = 1'b1;
            end else begin
                rxbuf_d   = rx_sh_q;
                rxvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ack_q      <= 1'b0;
            dat_q      <= 8'h00;
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txhold_q   <= '0;
            txfull_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_sync_q  <= '1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rxbuf_q    <= '0;
            rxvalid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            ack_q      <= access;
            dat_q      <= dat_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txhold_q   <= txhold_d;
            txfull_q   <= txfull_d;
            txd_q      <= txd_d;
            rx_sync_q  <= {rx_sync_q[RXSYNC-2:0], RXD};
            rx_prev_q  <= rxd_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rxbuf_q    <= rxbuf_d;
            rxvalid_q  <= rxvalid_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_m_wb_uart.sv
// Bench for m_wb_uart at 8 clocks per bit: table of register/RX operations,
// plus hand-written TX, back-to-back and reset-abort sequences.
module tb_m_wb_uart;

    localparam int unsigned Div = 8;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       CYC_I = 1'b0;
    logic       STB_I = 1'b0;
    logic       WE_I  = 1'b0;
    logic       ADR_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic [7:0] DAT_O;
    logic       ACK_O;
    logic       TXD;
    logic       RXD   = 1'b1;
    logic       irq;

    m_wb_uart #(
        .CLKDIV(Div),
        .RXSYNC(2)
    ) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .CYC_I(CYC_I),
        .STB_I(STB_I),
        .WE_I (WE_I),
        .ADR_I(ADR_I),
        .DAT_I(DAT_I),
        .DAT_O(DAT_O),
        .ACK_O(ACK_O),
        .TXD  (TXD),
        .RXD  (RXD),
        .irq  (irq)
    );

    always #5 CLK_I = ~CLK_I;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge CLK_I) cyc <= cyc + 1;

    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];

    typedef enum int {OpRdD, OpRdS, OpWrS, OpRx, OpRxBad, OpGlitch, OpIrq} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] val;
        logic [7:0] exp;
    } vec_t;

    function automatic vec_t mkv(input op_e o, input logic [7:0] a, input logic [7:0] e);
        vec_t r;
        r.op  = o;
        r.val = a;
        r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One Wishbone access, started on a falling edge; returns two falling edges
    // after ACK so the next access is a fresh strobe.
    task automatic bus(input logic we, input logic adr, input logic [7:0] wd,
                       input logic [7:0] exp);
        logic [7:0] e;
        if (!we) exp_rd.push_back(exp);
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = wd;
        check("ack_before_edge", ACK_O, 0);
        @(posedge CLK_I);
        #1;
        check("ack_one_cycle", ACK_O, 1);
        if (!we) begin
            e = exp_rd.pop_front();
            if (adr) check("rd_status", DAT_O, e);
            else     check("rd_data", DAT_O, e);
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        check("ack_single_pulse", ACK_O, 0);
    endtask

    // Wait for a start bit, then sample every clock for a whole frame.
    task automatic tx_capture(input int limit, output logic [7:0] b, output int t0);
        logic [79:0] s;
        logic        shape_ok;
        int          w;
        w = 0;
        b = 8'hxx;
        while (TXD !== 1'b0 && w < limit) begin
            @(negedge CLK_I);
            w++;
        end
        t0 = cyc;
        if (TXD !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL tx_start: TXD=%b, no start bit within %0d cycles", TXD, limit);
            return;
        end
        for (int i = 0; i < 80; i++) begin
            s[i] = TXD;
            if (i < 79) @(negedge CLK_I);
        end
        shape_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int j = 1; j < 8; j++) begin
                if (s[8*k+j] !== s[8*k]) shape_ok = 1'b0;
            end
        end
        for (int k = 0; k < 8; k++) b[k] = s[8*(k+1)+4];
        check("tx_bit_width", shape_ok, 1);
        check("tx_start_bit", s[0], 0);
        check("tx_stop_bit", s[72], 1);
        if (exp_tx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected_frame: got %0h want none", b);
        end else begin
            check("tx_byte", b, exp_tx.pop_front());
        end
    endtask

    task automatic tx_quiet(input string name, input int n);
        logic seen_low;
        seen_low = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (TXD !== 1'b1) seen_low = 1'b1;
            @(negedge CLK_I);
        end
        check(name, seen_low, 0);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            RXD = f[k];
            repeat (Div) @(negedge CLK_I);
        end
        RXD = 1'b1;
        repeat (Div) @(negedge CLK_I);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    vec_t       vt[25];
    logic [7:0] b1, b2;
    int         t1, t2;

    initial begin
        vt[0]  = mkv(OpRdS, 8'h00, 8'h01);
        vt[1]  = mkv(OpRdD, 8'h00, 8'h00);
        vt[2]  = mkv(OpIrq, 8'h00, 8'h00);
        vt[3]  = mkv(OpRx, 8'h3C, 8'h00);
        vt[4]  = mkv(OpIrq, 8'h00, 8'h01);
        vt[5]  = mkv(OpRdS, 8'h00, 8'h03);
        vt[6]  = mkv(OpRdD, 8'h00, 8'h3C);
        vt[7]  = mkv(OpRdS, 8'h00, 8'h01);
        vt[8]  = mkv(OpIrq, 8'h00, 8'h00);
        vt[9]  = mkv(OpRx, 8'h11, 8'h00);
        vt[10] = mkv(OpRx, 8'h22, 8'h00);
        vt[11] = mkv(OpRdS, 8'h00, 8'h07);
        vt[12] = mkv(OpRdD, 8'h00, 8'h11);
        vt[13] = mkv(OpRdS, 8'h00, 8'h05);
        vt[14] = mkv(OpIrq, 8'h00, 8'h01);
        vt[15] = mkv(OpWrS, 8'h04, 8'h00);
        vt[16] = mkv(OpRdS, 8'h00, 8'h01);
        vt[17] = mkv(OpIrq, 8'h00, 8'h00);
        vt[18] = mkv(OpGlitch, 8'h00, 8'h00);
        vt[19] = mkv(OpRdS, 8'h00, 8'h01);
        vt[20] = mkv(OpRxBad, 8'h5A, 8'h00);
        vt[21] = mkv(OpRdS, 8'h00, 8'h01);
        vt[22] = mkv(OpRx, 8'h81, 8'h00);
        vt[23] = mkv(OpRdD, 8'h00, 8'h81);
        vt[24] = mkv(OpRdS, 8'h00, 8'h01);

        repeat (3) @(negedge CLK_I);
        check("rst_txd", TXD, 1);
        check("rst_ack", ACK_O, 0);
        check("rst_irq", irq, 0);
        check("rst_dat_o", DAT_O, 0);
        RST_I = 1'b1;
        @(negedge CLK_I);

        for (int i = 0; i < 25; i++) begin
            case (vt[i].op)
                OpRdD:    bus(1'b0, 1'b0, 8'h00, vt[i].exp);
                OpRdS:    bus(1'b0, 1'b1, 8'h00, vt[i].exp);
                OpWrS:    bus(1'b1, 1'b1, vt[i].val, 8'h00);
                OpRx:     rx_send(vt[i].val, 1'b1);
                OpRxBad:  rx_send(vt[i].val, 1'b0);
                OpGlitch: begin
                    RXD = 1'b0;
                    repeat (3) @(negedge CLK_I);
                    RXD = 1'b1;
                    repeat (3 * Div) @(negedge CLK_I);
                end
                OpIrq:    check("irq", irq, vt[i].exp[0]);
                default:  ;
            endcase
        end

        // Single frame; busy holds through the stop bit and clears right after it.
        exp_tx.push_back(8'hA5);
        bus(1'b1, 1'b0, 8'hA5, 8'h00);
        tx_capture(20, b1, t1);
        bus(1'b0, 1'b1, 8'h00, 8'h09);
        bus(1'b0, 1'b1, 8'h00, 8'h01);

        // Second write lands once the first byte moved to the shifter; the third is dropped.
        exp_tx.push_back(8'h55);
        bus(1'b1, 1'b0, 8'h55, 8'h00);
        fork
            begin
                tx_capture(20, b1, t1);
                tx_capture(200, b2, t2);
            end
            begin
                exp_tx.push_back(8'h0F);
                bus(1'b1, 1'b0, 8'h0F, 8'h00);
                bus(1'b1, 1'b0, 8'h99, 8'h00);
            end
        join
        check("tx_frame_gap", t2 - t1, 10 * Div);
        tx_quiet("tx_dropped_write_quiet", 200);
        check("tx_pending", exp_tx.size(), 0);

        // Reset in the middle of a frame while a 0 data bit is on the line.
        bus(1'b1, 1'b0, 8'hC3, 8'h00);
        repeat (30) @(negedge CLK_I);
        check("pre_rst_txd_low", TXD, 0);
        RST_I = 1'b0;
        #1;
        check("async_rst_txd", TXD, 1);
        check("async_rst_ack", ACK_O, 0);
        check("async_rst_irq", irq, 0);
        @(negedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b1;
        @(negedge CLK_I);
        bus(1'b0, 1'b1, 8'h00, 8'h01);
        tx_quiet("post_rst_quiet", 120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_wb_uart.md
Name: m_wb_uart

Overview:
- Wishbone classic slave UART for midgetv boards; replaces the bit-banged usartTX/usartRX pins with a hardware transmitter and receiver.
- Sits directly downstream of m_midgetv_core's Wishbone master, decoded by the board top from the IO address region.
- Handles 8N1 framing at a fixed divisor-derived baud, with 1-byte TX holding register, 1-byte RX buffer and an overrun flag.

Parameters:
- CLKDIV, 104, CLK_I cycles per bit (12 MHz / 115200). Legal range 4..65535.
- RXSYNC, 2, number of synchroniser flops on RXD before sampling (2..3).

Ports:
- CLK_I  in  1  system clock, all logic on posedge.
- RST_I  in  1  asynchronous, active-low reset. Deassertion is synchronised externally.
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe; asserted only when the top's address decode selects this block.
- WE_I  in  1  write enable.
- ADR_I  in  1  register select: 0 = DATA, 1 = STATUS/CTRL.
- DAT_I  in  8  write data, byte lane 0.
- DAT_O  out  8  read data, valid while ACK_O = 1.
- ACK_O  out  1  Wishbone acknowledge.
- TXD  out  1  serial out, idle high.
- RXD  in  1  serial in, asynchronous.
- irq  out  1  level interrupt: rxvalid | overrun.

Behaviour:
- Reset (RST_I = 0):
  - ACK_O = 0, DAT_O = 0, TXD = 1, irq = 0.
  - txhold empty, tx FSM IDLE, rx FSM IDLE, rxvalid = 0, overrun = 0.
  - Baud counters cleared, synchroniser flops set to 1.
- Bus handshake:
  - ACK_O is registered: ACK_O <= CYC_I & STB_I & ~ACK_O. Every access takes exactly 2 cycles; back-to-back strobes get ACK every other cycle.
  - Side effects occur only in the cycle where ACK_O is set (registered), i.e. once per access.
- Register writes:
  - Write DATA: if txhold is empty, load DAT_I and mark it full. If full, drop the write silently; ACK still given.
  - Write STATUS: DAT_I[2] = 1 clears overrun. Other bits are ignored.
- Register reads:
  - Read DATA: DAT_O = rxbuf, and rxvalid is cleared in the same edge.
  - Read STATUS: DAT_O = {4'b0, txbusy, overrun, rxvalid, txready}.
    - txready = txhold empty.
    - txbusy = tx FSM not IDLE or txhold full.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when txhold is full, move txhold into the shift register, mark txhold empty, go to START with TXD = 0.
  - Each state lasts CLKDIV cycles, timed by a down-counter.
  - DATA: shift out 8 bits, LSB first.
  - STOP: TXD = 1 for CLKDIV cycles, then back to IDLE. If txhold is full at the end of STOP, START begins on the next cycle; no extra idle bit.
  - Byte-to-byte gap with a pre-loaded holding register is exactly 10*CLKDIV cycles.
- RX FSM (IDLE, START, DATA, STOP):
  - All decisions use the synchronised RXD (latency RXSYNC cycles).
  - IDLE: a falling edge starts a counter at CLKDIV/2 (integer divide), go to START.
  - START: at the half-bit point, if rxd = 1 the start was a glitch → IDLE; else reload CLKDIV.
  - DATA: sample 8 bits at CLKDIV intervals, LSB first.
  - STOP: at the stop-bit sample, if rxd = 1 the frame is good:
    - If rxvalid is already 1, set overrun and keep the old rxbuf.
    - Else load rxbuf and set rxvalid.
  - If the stop bit is 0 (framing error), discard the byte and do not set rxvalid.
  - Return to IDLE immediately after the stop sample, so a start edge half a bit later is accepted.
- Simultaneous events:
  - A DATA read clearing rxvalid in the same cycle as a new good frame: the read wins the clear, the new byte loads, and rxvalid stays 1; no overrun.
  - A STATUS write clearing overrun in the same cycle overrun is set: overrun remains 1.
- Reset mid-frame aborts both FSMs at once; TXD returns to 1 asynchronously.

Test Plan:
- Reset → TXD = 1, ACK_O = 0, STATUS read = 0x01. Each access ACKs exactly 1 cycle after STB_I rises.
- CLKDIV = 8; write DATA 0xA5 → TXD low 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high 8 cycles. txbusy drops 80 cycles after ACK.
- Two back-to-back DATA writes 0x55, 0x0F → second accepted (txready was 1 after first moved to shifter), frames contiguous with no gap. A third write while txhold is full is dropped; TXD never shows it.
- Drive RXD frame 0x3C at 8 cycles/bit → rxvalid = 1, irq = 1, DATA read = 0x3C, and a subsequent STATUS read shows rxvalid = 0.
- Two RX frames without a read → overrun = 1, DATA read = first byte. Write STATUS 0x04 → overrun = 0, irq = 0.
- RXD low pulse of 3 cycles → no frame, rxvalid stays 0. A frame with stop bit 0 → discarded. Assert RST_I = 0 mid-TX → TXD = 1 immediately, and STATUS = 0x01 after release.
